// File: rtl/irom_boot_loader_if.sv
// Instruction stream and IROM write port of the boot loader.
// s_data is taken on any cycle where s_valid && s_ready; the source holds s_data/s_valid until then.
interface irom_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       s_data;
    logic              s_valid;
    logic              s_ready;
    logic              irom_wr_en;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  irom_wr_en,
        input  irom_addr,
        input  irom_wdata
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output irom_wr_en,
        output irom_addr,
        output irom_wdata
    );
endinterface

// File: rtl/irom_boot_loader.sv
// Setup-phase sequencer: streams instruction words into the IROM, holds the
// decoder in setup while loading and settling, then releases the core.
module irom_boot_loader #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    irom_boot_loader_if.slave bus,
    output logic              setup,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [3:0]      SETTLE_L = SETTLE_CYC[3:0];

    state_t          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [3:0]      settle_q, settle_d;

    logic len_ok;
    logic can_start;
    logic start_acc;
    logic start_rej;
    logic abort_acc;
    logic ready_c;
    logic xfer;
    logic last_xfer;

    // Qualifiers; abort takes priority over start in every state.
    always_comb begin
        len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
        can_start = (state_q == ST_IDLE) || (state_q == ST_RUN);
        start_acc = start && !abort && can_start && len_ok;
        start_rej = start && !abort && can_start && !len_ok;
        abort_acc = abort && ((state_q == ST_LOAD) || (state_q == ST_SETTLE));
        ready_c   = (state_q == ST_LOAD) && !abort;
        xfer      = ready_c && bus.s_valid;
        last_xfer = xfer && (cnt_q == (len_q - CNT_ONE));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start_acc) begin
                    state_d = ST_LOAD;
                    len_d   = load_len;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (abort_acc) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_xfer) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                // First SETTLE cycle carries the final write strobe, then SETTLE_CYC quiet cycles.
                if (abort_acc) begin
                    state_d = ST_IDLE;
                end else if (settle_q == SETTLE_L) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            settle_q <= settle_d;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup    <= 1'b0;
            core_run <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            setup    <= (state_d == ST_LOAD) || (state_d == ST_SETTLE);
            core_run <= (state_d == ST_RUN);
            done     <= (state_d == ST_RUN) && (state_q != ST_RUN);
            err      <= start_rej || abort_acc;
        end
    end

    // IROM write port: one-cycle strobe per accepted word, address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.irom_wr_en <= 1'b0;
            bus.irom_addr  <= '0;
            bus.irom_wdata <= '0;
        end else begin
            bus.irom_wr_en <= xfer;
            if (xfer) begin
                bus.irom_addr  <= cnt_q[ADDR_W-1:0];
                bus.irom_wdata <= bus.s_data;
            end
        end
    end

    assign bus.s_ready = ready_c;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign state_dbg   = state_q;

endmodule
